// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - lsu access sizes, FSM state encodings and alignment helper
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int LSU_TIMEOUT = 255;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte enables and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be       = 4'b1111;
    st_lanes = st_data;
    case (size)
      SIZE_B: begin
        be       = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        be       = 4'b0011 << addr_lo;
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/halfword down to bit 0 before extending.
  always_comb begin
    shifted = ld_word >> {addr_lo, 3'b000};
    case (size)
      SIZE_B:  ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: dbus req/gnt/rvalid FSM, timeout, core stall
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int TIMEOUT_CYCLS = LSU_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_valid_i,
  input  logic            lsu_ld_i,
  input  logic            lsu_st_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_unsigned_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_stall_o,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rd_wdata_o,
  output logic            lsu_ld_misalign_o,
  output logic            lsu_st_misalign_o,
  output logic            lsu_bus_err_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_err_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLS + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLS - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            err_q;

  logic mem_op, mis, go, busy, resp, timeout;
  logic [3:0]      be;
  logic [XLEN-1:0] st_lanes, ld_data;

  assign mem_op  = lsu_valid_i & (lsu_ld_i ^ lsu_st_i) & (lsu_size_i != 2'b11);
  assign mis     = mem_op & misaligned(lsu_size_i, lsu_addr_i[1:0]);
  assign go      = mem_op & ~mis;
  assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign timeout = busy && (cnt_q == TO_LAST);

  // The request goes out combinationally in IDLE so a same-cycle grant saves a cycle.
  assign dbus_req_o = ~reset & (((state_q == ST_IDLE) & go) | (state_q == ST_REQ));
  assign resp       = (dbus_req_o & dbus_gnt_i & dbus_rvalid_i) |
                      ((state_q == ST_WAIT) & dbus_rvalid_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = resp ? ST_DONE : (dbus_gnt_i ? ST_WAIT : ST_REQ);
      ST_REQ:  if (resp || timeout) state_d = ST_DONE;
               else if (dbus_gnt_i) state_d = ST_WAIT;
      ST_WAIT: if (resp || timeout) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= busy ? cnt_q + CW'(1) : '0;
      if (resp) begin
        result_q <= dbus_rdata_i;
        err_q    <= dbus_err_i;
      end else if (timeout) begin
        result_q <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  // Inputs stay held through DONE (pc stalled until then), so formatting can use them live.
  lsu_align u_align (
    .size        (lsu_size_i),
    .addr_lo     (lsu_addr_i[1:0]),
    .is_unsigned (lsu_unsigned_i),
    .st_data     (lsu_wdata_i),
    .ld_word     (result_q),
    .be          (be),
    .st_lanes    (st_lanes),
    .ld_data     (ld_data)
  );

  assign lsu_done_o        = (state_q == ST_DONE);
  assign lsu_bus_err_o     = lsu_done_o & err_q;
  assign lsu_rd_wdata_o    = (lsu_done_o & ~err_q & lsu_ld_i) ? ld_data : '0;
  assign lsu_stall_o       = go & (state_q != ST_DONE);
  assign lsu_ld_misalign_o = mis & lsu_ld_i;
  assign lsu_st_misalign_o = mis & lsu_st_i;

  assign dbus_we_o    = dbus_req_o & lsu_st_i;
  assign dbus_addr_o  = dbus_req_o ? {lsu_addr_i[XLEN-1:2], 2'b00} : '0;
  assign dbus_be_o    = dbus_req_o ? be : 4'b0000;
  assign dbus_wdata_o = dbus_req_o ? st_lanes : '0;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu with directed bus transactions
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid_i, lsu_ld_i, lsu_st_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_stall_o, lsu_done_o, lsu_ld_misalign_o, lsu_st_misalign_o, lsu_bus_err_o;
  logic [31:0] lsu_rd_wdata_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
  logic [31:0] dbus_rdata_i;

  always #5 clk = ~clk;

  lsu #(.XLEN(32), .TIMEOUT_CYCLS(4)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid_i(lsu_valid_i), .lsu_ld_i(lsu_ld_i), .lsu_st_i(lsu_st_i),
    .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .lsu_rd_wdata_o(lsu_rd_wdata_o),
    .lsu_ld_misalign_o(lsu_ld_misalign_o), .lsu_st_misalign_o(lsu_st_misalign_o),
    .lsu_bus_err_o(lsu_bus_err_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i)
  );

  typedef struct {
    logic        chk_data;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    #3;
    if (lsu_done_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 expected no response");
      end else begin
        e = sb.pop_front();
        chk("resp_bus_err", {31'd0, lsu_bus_err_o}, {31'd0, e.err});
        if (e.chk_data) chk("resp_rd_wdata", lsu_rd_wdata_o, e.rd);
      end
    end
  end

  task automatic set_op(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    lsu_valid_i = v; lsu_ld_i = ld; lsu_st_i = st; lsu_size_i = sz;
    lsu_unsigned_i = uns; lsu_addr_i = a; lsu_wdata_i = wd;
  endtask

  // One aligned access: gwait grant-low cycles, grant, then rvalid the following cycle.
  task automatic access(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int gwait,
                        input logic [31:0] rd, input logic er, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    int stalls;
    exp_t e;
    @(negedge clk);
    set_op(1'b1, ~st, st, sz, uns, a, wd);
    dbus_rvalid_i = 1'b0;
    e.chk_data = ~st; e.rd = exp_rd; e.err = er;
    sb.push_back(e);
    stalls = 0;
    for (int i = 0; i <= gwait; i++) begin
      dbus_gnt_i = (i == gwait);
      #1;
      chk("req_held", {31'd0, dbus_req_o}, 32'd1);
      chk("addr_word", dbus_addr_o, {a[31:2], 2'b00});
      chk("be", {28'd0, dbus_be_o}, {28'd0, exp_be});
      chk("we", {31'd0, dbus_we_o}, {31'd0, st});
      if (st) chk("wdata_lanes", dbus_wdata_o, exp_wd);
      if (lsu_stall_o) stalls++;
      @(negedge clk);
    end
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = rd; dbus_err_i = er;
    #1;
    chk("req_low_in_wait", {31'd0, dbus_req_o}, 32'd0);
    if (lsu_stall_o) stalls++;
    @(negedge clk);
    dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0;
    #1;
    chk("stall_low_in_done", {31'd0, lsu_stall_o}, 32'd0);
    chk("stall_cycles", stalls, gwait + 2);
    @(negedge clk);
    lsu_valid_i = 1'b0;
  endtask

  initial begin : stim
    int  stalls;
    logic ok;
    exp_t e;
    reset = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", {31'd0, lsu_done_o}, 32'd0);
    chk("rst_bus_err", {31'd0, lsu_bus_err_o}, 32'd0);
    chk("rst_rd_wdata", lsu_rd_wdata_o, 32'd0);
    chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LW, LB/LBU, LH/LHU, SH with grant delay, SB, error response
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF);
    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80);
    access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0, 4'b1000, 32'h0, 32'h00000080);
    access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001);
    access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'h00008001);
    access(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 3, 32'h0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
    access(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 0, 32'h0, 1'b0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 32'hFFFFFFFF, 1'b1, 4'b1111, 32'h0, 32'h0);

    // Misaligned and illegal decodes: no request, no stall, same cycle
    @(negedge clk);
    set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    #1;
    chk("lw_mis_flag", {31'd0, lsu_ld_misalign_o}, 32'd1);
    chk("lw_mis_st_flag", {31'd0, lsu_st_misalign_o}, 32'd0);
    chk("lw_mis_req", {31'd0, dbus_req_o}, 32'd0);
    chk("lw_mis_stall", {31'd0, lsu_stall_o}, 32'd0);
    @(negedge clk);
    set_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0);
    #1;
    chk("sw_mis_flag", {31'd0, lsu_st_misalign_o}, 32'd1);
    chk("sw_mis_req", {31'd0, dbus_req_o}, 32'd0);
    @(negedge clk);
    set_op(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    chk("ldst_both_stall", {31'd0, lsu_stall_o}, 32'd0);
    chk("ldst_both_req", {31'd0, dbus_req_o}, 32'd0);
    @(negedge clk);
    set_op(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    #1;
    chk("size11_stall", {31'd0, lsu_stall_o}, 32'd0);
    chk("size11_req", {31'd0, dbus_req_o}, 32'd0);

    // Timeout: granted, no rvalid; 1 IDLE cycle + 4 WAIT cycles of stall
    @(negedge clk);
    set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    dbus_gnt_i = 1'b1;
    e.chk_data = 1'b1; e.rd = 32'h0; e.err = 1'b1;
    sb.push_back(e);
    stalls = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (lsu_stall_o) stalls++; else ok = 1'b1;
      @(negedge clk);
      dbus_gnt_i = 1'b0;
    end
    lsu_valid_i = 1'b0;
    chk("timeout_reached", {31'd0, ok}, 32'd1);
    chk("timeout_stalls", stalls, 5);

    // Reset while waiting for rvalid; a later rvalid must be ignored
    @(negedge clk);
    set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    dbus_gnt_i = 1'b1;
    #1;
    chk("rst_case_req", {31'd0, dbus_req_o}, 32'd1);
    @(negedge clk);
    dbus_gnt_i = 1'b0; reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst_mid_stall", {31'd0, lsu_stall_o}, 32'd1);
    @(negedge clk);
    reset = 1'b0; lsu_valid_i = 1'b0;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h12345678;
    #1;
    chk("post_rst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("post_rst_stall", {31'd0, lsu_stall_o}, 32'd0);
    chk("post_rst_done", {31'd0, lsu_done_o}, 32'd0);
    @(negedge clk);
    dbus_rvalid_i = 1'b0;
    #1;
    chk("late_rvalid_ignored", {31'd0, lsu_done_o}, 32'd0);

    repeat (3) @(negedge clk);
    #4;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
